alu_seq: RTL and testbench

Sequential, parametrised successor of the single-cycle integer ALU. It adds a valid/ready handshake, a registered result, and iterative multiply/divide/remainder with RISC-V M-extension semantics on top of the existing logic, shift, add/sub and compare operations. It sits in the execute stage between the operand-issue logic and writeback, and can stall the pipeline while an iterative operation runs.

---
 rtl/alu_pkg.sv | 83 ++++++++
 rtl/alu_muldiv_iter.sv | 120 ++++++++++++
 rtl/alu_seq.sv | 108 ++++++++++
 tb/tb_alu_seq.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
//   - op-code localparams for the base set (bit 4 = 0) and the M set (bit 4 = 1)
//   - FSM state encoding for the top level
//   - alu_base_result(): combinational result of the base operations, computed
//     on ALU_MAXW-bit containers so one function serves any WIDTH up to ALU_MAXW
package alu_pkg;

    localparam int unsigned ALU_MAXW = 64;

    // Base operations
    localparam logic [4:0] OP_AND    = 5'd0;
    localparam logic [4:0] OP_OR     = 5'd1;
    localparam logic [4:0] OP_ADD    = 5'd2;
    localparam logic [4:0] OP_EQ     = 5'd3;
    localparam logic [4:0] OP_SLL    = 5'd4;
    localparam logic [4:0] OP_SRL    = 5'd5;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_XOR    = 5'd8;
    localparam logic [4:0] OP_NOR    = 5'd9;
    localparam logic [4:0] OP_SUB    = 5'd10;
    localparam logic [4:0] OP_SGE    = 5'd12;
    localparam logic [4:0] OP_SGEU   = 5'd13;
    localparam logic [4:0] OP_SLT    = 5'd14;
    localparam logic [4:0] OP_SLTU   = 5'd15;

    // M operations (iterative)
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_MULHU  = 5'd19;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam logic [4:0] OP_REMU   = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } alu_state_e;

    // a and b arrive zero-extended from w bits; signed views are rebuilt by
    // sign-extending from bit w-1. The result is masked back to w bits.
    function automatic logic [ALU_MAXW-1:0] alu_base_result(
        input logic [4:0]          op,
        input logic [ALU_MAXW-1:0] a,
        input logic [ALU_MAXW-1:0] b,
        input logic [5:0]          sh,
        input int unsigned         w
    );
        logic [ALU_MAXW-1:0] mask;
        logic [ALU_MAXW-1:0] sbit;
        logic [ALU_MAXW-1:0] a_s;
        logic [ALU_MAXW-1:0] b_s;
        logic [ALU_MAXW-1:0] r;
        logic                lt_s;
        mask = (w >= ALU_MAXW) ? '1 : ((ALU_MAXW'(1) << w) - ALU_MAXW'(1));
        sbit = ALU_MAXW'(1) << (w - 1);
        a_s  = ((a & sbit) != '0) ? (a | ~mask) : a;
        b_s  = ((b & sbit) != '0) ? (b | ~mask) : b;
        lt_s = $signed(a_s) < $signed(b_s);
        r    = '0;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_EQ:   r = ALU_MAXW'(a == b);
            OP_SLL:  r = a << sh;
            OP_SRL:  r = a >> sh;
            OP_SRA:  r = ALU_MAXW'($signed(a_s) >>> sh);
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            OP_SUB:  r = a - b;
            OP_SGE:  r = ALU_MAXW'(!lt_s);
            OP_SGEU: r = ALU_MAXW'(a >= b);
            OP_SLT:  r = ALU_MAXW'(lt_s);
            OP_SLTU: r = ALU_MAXW'(a < b);
            default: r = '0;
        endcase
        return r & mask;
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply / divide / remainder unit (RISC-V M semantics).
// One radix-2 step per cycle on operand magnitudes; signs are applied to the
// value produced by the final step, so result_o is valid in the done_o cycle.
//   clk_i    clock
//   rstn_i   synchronous active-low reset
//   start_i  load operands and begin (must only be pulsed while idle)
//   op_i     low three op bits: [2] = divide, [1:0] = variant
//   rs1_i    operand 1 / dividend
//   rs2_i    operand 2 / divisor
//   done_o   strobe: final step in this cycle, result_o valid
//   result_o sign-corrected result
module alu_muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] rs1_i,
    input  logic [WIDTH-1:0] rs2_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic             busy_q;
    logic [CW-1:0]    cnt_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] acc_q;    // high product half / partial remainder
    logic [WIDTH-1:0] quo_q;    // low product half (multiplier) / dividend-quotient
    logic [WIDTH-1:0] opb_q;    // multiplicand / divisor magnitude
    logic             negq_q;   // negate product or quotient
    logic             negr_q;   // negate remainder (dividend sign)
    logic             div0_q;
    logic [WIDTH-1:0] rs1_q;

    logic             a_signed, b_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_r;
    logic [WIDTH+1:0] div_diff;
    logic [WIDTH-1:0] acc_d, quo_d;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] quo_s, rem_s;

    // Signedness: MUL/MULH s*s, MULHSU s*u, MULHU u*u; DIV/REM signed, DIVU/REMU unsigned
    always_comb begin
        a_signed = op_i[2] ? !op_i[0] : (op_i[1:0] != 2'd3);
        b_signed = op_i[2] ? !op_i[0] : !op_i[1];
        a_neg    = a_signed & rs1_i[WIDTH-1];
        b_neg    = b_signed & rs2_i[WIDTH-1];
        a_mag    = a_neg ? -rs1_i : rs1_i;
        b_mag    = b_neg ? -rs2_i : rs2_i;
    end

    always_comb begin
        mul_sum  = {1'b0, acc_q} + (quo_q[0] ? {1'b0, opb_q} : '0);
        div_r    = {acc_q, quo_q[WIDTH-1]};
        div_diff = {1'b0, div_r} - {2'b00, opb_q};
        if (op_q[2]) begin
            // restoring divide: keep the difference only when it did not borrow
            if (!div_diff[WIDTH+1]) begin
                acc_d = WIDTH'(div_diff);
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = WIDTH'(div_r);
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_d = mul_sum[WIDTH:1];
            quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod_s = negq_q ? -{acc_d, quo_d} : {acc_d, quo_d};
        quo_s  = negq_q ? -quo_d : quo_d;
        rem_s  = negr_q ? -acc_d : acc_d;
        if (op_q[2]) begin
            if (div0_q) result_o = op_q[1] ? rs1_q : '1;
            else        result_o = op_q[1] ? rem_s : quo_s;
        end else begin
            result_o = (op_q[1:0] == 2'd0) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
        end
        done_o = busy_q && (cnt_q == '0);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            op_q   <= '0;
            acc_q  <= '0;
            quo_q  <= '0;
            opb_q  <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            div0_q <= 1'b0;
            rs1_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= CW'(WIDTH - 1);
            op_q   <= op_i;
            acc_q  <= '0;
            quo_q  <= a_mag;
            opb_q  <= b_mag;
            negq_q <= a_neg ^ b_neg;
            negr_q <= a_neg;
            div0_q <= op_i[2] && (rs2_i == '0);
            rs1_q  <= rs1_i;
        end else if (busy_q) begin
            acc_q <= acc_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake and registered result.
// Base ops complete one cycle after accept; M ops (codes 16-23) run through
// alu_muldiv_iter and complete WIDTH+1 cycles after accept.
//   CLK_i        clock
//   RSTN_i       synchronous active-low reset
//   ALU_OP_i     operation code
//   ALU_RS1_i    operand 1
//   ALU_RS2_i    operand 2
//   IN_VALID_i   request valid
//   IN_READY_o   ready to accept (IDLE only)
//   ALU_RD_o     registered result
//   ALU_ZR_o     result is zero
//   OUT_VALID_o  result valid (DONE)
//   OUT_READY_i  consumer takes result
//   BUSY_o       iterative op in progress
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             CLK_i,
    input  logic             RSTN_i,
    input  logic [4:0]       ALU_OP_i,
    input  logic [WIDTH-1:0] ALU_RS1_i,
    input  logic [WIDTH-1:0] ALU_RS2_i,
    input  logic             IN_VALID_i,
    output logic             IN_READY_o,
    output logic [WIDTH-1:0] ALU_RD_o,
    output logic             ALU_ZR_o,
    output logic             OUT_VALID_o,
    input  logic             OUT_READY_i,
    output logic             BUSY_o
);

    alu_state_e          state_q;
    logic [WIDTH-1:0]    rd_q;
    logic                zr_q;

    logic                accept;
    logic                is_md;
    logic                md_start;
    logic                md_done;
    logic [WIDTH-1:0]    md_res;
    logic [ALU_MAXW-1:0] base_full;
    logic [WIDTH-1:0]    base_res;

    always_comb begin
        accept    = IN_VALID_i && (state_q == ST_IDLE);
        is_md     = ALU_OP_i[4] && !ALU_OP_i[3];
        md_start  = accept && is_md;
        base_full = alu_base_result(ALU_OP_i, ALU_MAXW'(ALU_RS1_i), ALU_MAXW'(ALU_RS2_i),
                                    6'(ALU_RS2_i[SHW-1:0]), WIDTH);
        // codes 24-31 share the base-op path and yield zero
        base_res  = ALU_OP_i[4] ? '0 : WIDTH'(base_full);
    end

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk_i    (CLK_i),
        .rstn_i   (RSTN_i),
        .start_i  (md_start),
        .op_i     (ALU_OP_i[2:0]),
        .rs1_i    (ALU_RS1_i),
        .rs2_i    (ALU_RS2_i),
        .done_o   (md_done),
        .result_o (md_res)
    );

    always_ff @(posedge CLK_i) begin
        if (!RSTN_i) begin
            state_q <= ST_IDLE;
            rd_q    <= '0;
            zr_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_md) begin
                            state_q <= ST_BUSY;
                        end else begin
                            rd_q    <= base_res;
                            zr_q    <= (base_res == '0);
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_BUSY: begin
                    if (md_done) begin
                        rd_q    <= md_res;
                        zr_q    <= (md_res == '0);
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (OUT_READY_i) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign IN_READY_o  = (state_q == ST_IDLE);
    assign OUT_VALID_o = (state_q == ST_DONE);
    assign BUSY_o      = (state_q == ST_BUSY);
    assign ALU_RD_o    = rd_q;
    assign ALU_ZR_o    = zr_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: drives a 32-bit and an 8-bit instance (one
// selected at a time), predicts results and latency with an arithmetic model.
module tb_alu_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn = 1'b0;
    logic        sel8 = 1'b0;
    logic [4:0]  op   = '0;
    logic [31:0] rs1  = '0;
    logic [31:0] rs2  = '0;
    logic        iv   = 1'b0;
    logic        ordy = 1'b0;

    logic        ir32, zr32, ov32, busy32;
    logic [31:0] rd32;
    logic        ir8, zr8, ov8, busy8;
    logic [7:0]  rd8;

    logic        ir, zr, ov, busy;
    logic [31:0] rd;

    alu_seq #(.WIDTH(32)) u_dut32 (
        .CLK_i(clk), .RSTN_i(rstn), .ALU_OP_i(op), .ALU_RS1_i(rs1), .ALU_RS2_i(rs2),
        .IN_VALID_i(iv & ~sel8), .IN_READY_o(ir32), .ALU_RD_o(rd32), .ALU_ZR_o(zr32),
        .OUT_VALID_o(ov32), .OUT_READY_i(ordy), .BUSY_o(busy32)
    );

    alu_seq #(.WIDTH(8)) u_dut8 (
        .CLK_i(clk), .RSTN_i(rstn), .ALU_OP_i(op), .ALU_RS1_i(rs1[7:0]), .ALU_RS2_i(rs2[7:0]),
        .IN_VALID_i(iv & sel8), .IN_READY_o(ir8), .ALU_RD_o(rd8), .ALU_ZR_o(zr8),
        .OUT_VALID_o(ov8), .OUT_READY_i(ordy), .BUSY_o(busy8)
    );

    assign ir   = sel8 ? ir8   : ir32;
    assign ov   = sel8 ? ov8   : ov32;
    assign zr   = sel8 ? zr8   : zr32;
    assign busy = sel8 ? busy8 : busy32;
    assign rd   = sel8 ? {24'd0, rd8} : rd32;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int unsigned acc;
        int unsigned lat;
    } exp_t;
    exp_t sb_q[$];

    bit hold_req = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: RISC-V style semantics on w-bit values using plain arithmetic
    function automatic logic [31:0] ref_alu(input logic [4:0] o, input logic [31:0] a,
                                            input logic [31:0] b, input int w);
        logic [63:0] m, ua, ub, r;
        longint sa, sb, minv;
        int sh;
        m    = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & m;
        ub   = {32'd0, b} & m;
        sa   = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
        sb   = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
        minv = -(longint'(1) << (w - 1));
        sh   = int'(ub % 64'(w));
        case (o)
            5'd0:  r = ua & ub;
            5'd1:  r = ua | ub;
            5'd2:  r = ua + ub;
            5'd3:  r = (ua == ub) ? 64'd1 : 64'd0;
            5'd4:  r = ua << sh;
            5'd5:  r = ua >> sh;
            5'd7:  r = 64'(sa >>> sh);
            5'd8:  r = ua ^ ub;
            5'd9:  r = ~(ua | ub);
            5'd10: r = ua - ub;
            5'd12: r = (sa >= sb) ? 64'd1 : 64'd0;
            5'd13: r = (ua >= ub) ? 64'd1 : 64'd0;
            5'd14: r = (sa < sb) ? 64'd1 : 64'd0;
            5'd15: r = (ua < ub) ? 64'd1 : 64'd0;
            5'd16: r = 64'(sa * sb);
            5'd17: r = 64'((sa * sb) >>> w);
            5'd18: r = 64'((sa * longint'(ub)) >>> w);
            5'd19: r = (ua * ub) >> w;
            5'd20: r = (ub == 0) ? m : (sa == minv && sb == -1) ? ua : 64'(sa / sb);
            5'd21: r = (ub == 0) ? m : ua / ub;
            5'd22: r = (ub == 0) ? ua : (sa == minv && sb == -1) ? 64'd0 : 64'(sa % sb);
            5'd23: r = (ub == 0) ? ua : ua % ub;
            default: r = 64'd0;
        endcase
        r = r & m;
        return r[31:0];
    endfunction

    // Issue one op; entered and left at a negedge. Inputs toggle randomly while
    // the DUT is not ready, to show they are ignored.
    task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   n = 0;
        int   w = sel8 ? 8 : 32;
        while (!ir) begin
            iv  = 1'($urandom_range(0, 1));
            op  = 5'($urandom);
            rs1 = $urandom;
            rs2 = $urandom;
            @(negedge clk);
            n++;
            if (n > 100) begin
                check("issue_timeout", 32'(ir), 32'd1);
                iv = 1'b0;
                return;
            end
        end
        iv  = 1'b1;
        op  = o;
        rs1 = a;
        rs2 = b;
        @(posedge clk);
        #1;
        e.op  = o;
        e.a   = a;
        e.b   = b;
        e.res = ref_alu(o, a, b, w);
        e.acc = cyc;
        e.lat = (o >= 5'd16 && o <= 5'd23) ? 32'(w + 1) : 32'd1;
        sb_q.push_back(e);
        iv  = 1'b0;
        op  = 5'($urandom);
        rs1 = $urandom;
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || ov) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", sb_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor + consumer
    initial begin : monitor
        bit          seen = 1'b0;
        bit          hs   = 1'b0;
        int          hold_left = 0;
        logic [32:0] held;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                seen = 1'b0; hs = 1'b0; hold_left = 0; ordy = 1'b0;
                continue;
            end
            check("ready_decode", 32'(ir), 32'(!(busy || ov)));
            if (hs) begin
                check("idle_after_handshake", {30'd0, ir, ov}, 32'd2);
                hs = 1'b0;
            end
            if (ov) begin
                if (!seen) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check($sformatf("result op%0d %h,%h", e.op, e.a, e.b), rd, e.res);
                        check($sformatf("zero op%0d", e.op), 32'(zr), 32'(e.res == 32'd0));
                        check($sformatf("latency op%0d", e.op), cyc - e.acc + 1, e.lat);
                    end
                    seen = 1'b1;
                    held = {zr, rd};
                    if (hold_req) begin
                        hold_left = 10;
                        hold_req  = 1'b0;
                    end
                end else begin
                    check("hold_stable", 32'({zr, rd} != held), 32'd0);
                end
                if (hold_left > 0) begin
                    ordy = 1'b0;
                    hold_left--;
                end else begin
                    ordy = ($urandom_range(0, 3) != 0);
                end
                if (ordy) begin
                    seen = 1'b0;
                    hs   = 1'b1;
                end
            end else begin
                ordy = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic random_ops(input int count);
        logic [4:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < count; i++) begin
            o = 5'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: a = sel8 ? 32'h80 : 32'h8000_0000;
                default: ;
            endcase
            issue(o, a, b);
        end
    endtask

    initial begin : main
        repeat (3) @(posedge clk);
        #1;
        check("reset_rd",    rd,         32'd0);
        check("reset_zr",    32'(zr),    32'd1);
        check("reset_valid", 32'(ov),    32'd0);
        check("reset_ready", 32'(ir),    32'd1);
        check("reset_busy",  32'(busy),  32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Directed, WIDTH = 32
        issue(5'd2,  32'h7FFF_FFFF, 32'd1);
        issue(5'd10, 32'd5,         32'd5);
        issue(5'd7,  32'h8000_0000, 32'd31);
        issue(5'd15, 32'd1,         32'hFFFF_FFFF);
        issue(5'd14, 32'd1,         32'hFFFF_FFFF);
        issue(5'd17, 32'h8000_0000, 32'h8000_0000);
        issue(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(5'd20, 32'hFFFF_FFF9, 32'd2);
        issue(5'd22, 32'hFFFF_FFF9, 32'd2);
        issue(5'd21, 32'h1234_5678, 32'd0);
        issue(5'd22, 32'd9,         32'd0);
        issue(5'd20, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(5'd22, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(5'd6,  32'hDEAD_BEEF, 32'h1);
        issue(5'd11, 32'hDEAD_BEEF, 32'h1);
        issue(5'd27, 32'hDEAD_BEEF, 32'h1);
        drain();

        // Hold the result for 10 cycles while new requests are presented
        hold_req = 1'b1;
        issue(5'd16, 32'hFFFF_FFFD, 32'd7);
        issue(5'd2,  32'd40,        32'd2);
        drain();

        random_ops(150);
        drain();

        // Reset in the middle of a divide
        issue(5'd20, 32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        check("busy_mid_div", 32'(busy), 32'd1);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_rd",    rd,        32'd0);
        check("rst_mid_zr",    32'(zr),   32'd1);
        check("rst_mid_valid", 32'(ov),   32'd0);
        check("rst_mid_ready", 32'(ir),   32'd1);
        check("rst_mid_busy",  32'(busy), 32'd0);
        sb_q.delete();
        rstn = 1'b1;
        @(negedge clk);
        issue(5'd2, 32'd2, 32'd3);
        drain();

        // WIDTH = 8 instance
        @(posedge clk);
        #1;
        sel8 = 1'b1;
        @(negedge clk);
        issue(5'd17, 32'h80, 32'h80);
        issue(5'd19, 32'hFF, 32'hFF);
        issue(5'd16, 32'hF3, 32'h05);
        issue(5'd20, 32'hF9, 32'h02);
        issue(5'd22, 32'hF9, 32'h02);
        issue(5'd20, 32'h80, 32'hFF);
        issue(5'd22, 32'h80, 32'hFF);
        issue(5'd21, 32'h37, 32'h00);
        issue(5'd23, 32'h37, 32'h00);
        issue(5'd7,  32'h80, 32'h07);
        random_ops(80);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
